// File: rtl/sig_pkg.sv
// Shared types for the two-channel sine ROM scheduler.
package sig_pkg;
   localparam int NUM_CH = 2;

   typedef logic ch_id_t;

   typedef struct packed {
      logic   valid;
      ch_id_t tag;
   } inflight_t;
endpackage

// File: rtl/sine_rom_sched_if.sv
// Control, ROM bus and sample outputs of sine_rom_sched; master is the scheduler side.
interface sine_rom_sched_if #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 8
);
   logic                     en;
   logic                     tick;
   logic                     ph_clr;
   logic [ADDRESS_WIDTH-1:0] incr0;
   logic [ADDRESS_WIDTH-1:0] incr1;
   logic [ADDRESS_WIDTH-1:0] rom_addr;
   logic [DATA_WIDTH-1:0]    rom_dout;
   logic [DATA_WIDTH-1:0]    dout0;
   logic [DATA_WIDTH-1:0]    dout1;
   logic                     valid0;
   logic                     valid1;
   logic                     overrun;

   modport master (
      input  en, tick, ph_clr, incr0, incr1, rom_dout,
      output rom_addr, dout0, dout1, valid0, valid1, overrun
   );

   modport slave (
      output en, tick, ph_clr, incr0, incr1, rom_dout,
      input  rom_addr, dout0, dout1, valid0, valid1, overrun
   );
endinterface

// File: rtl/sine_rom_sched_rr_arb2.sv
// Two-way round-robin grant; rr_ptr picks the winner only when both channels request.
module rr_arb2
   import sig_pkg::*;
(
   input  logic [NUM_CH-1:0] pending_i,
   input  ch_id_t            rr_ptr_i,
   output logic              grant_valid_o,
   output ch_id_t            grant_id_o
);
   assign grant_valid_o = |pending_i;
   assign grant_id_o    = (&pending_i) ? rr_ptr_i : ch_id_t'(pending_i[1]);
endmodule

// File: rtl/sine_rom_sched.sv
// Shares one synchronous sine ROM between two phase-accumulator channels,
// issuing one read per cycle and routing the returned word to its owner.
module sine_rom_sched
   import sig_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   sine_rom_sched_if.master bus
);
   logic [ADDRESS_WIDTH-1:0] phase_q [NUM_CH];
   logic [ADDRESS_WIDTH-1:0] incr_w  [NUM_CH];
   logic [DATA_WIDTH-1:0]    dout_q  [NUM_CH];
   logic [NUM_CH-1:0]        pending_q;
   logic [NUM_CH-1:0]        valid_q;
   ch_id_t                   rr_ptr_q;
   inflight_t                infl_q;
   logic                     overrun_q;
   logic                     gnt_valid;
   ch_id_t                   gnt_id;
   logic                     tick_acc;

   assign incr_w[0] = bus.incr0;
   assign incr_w[1] = bus.incr1;
   assign tick_acc  = bus.tick & bus.en;

   rr_arb2 u_arb (
      .pending_i     (pending_q),
      .rr_ptr_i      (rr_ptr_q),
      .grant_valid_o (gnt_valid),
      .grant_id_o    (gnt_id)
   );

   assign bus.rom_addr = gnt_valid ? phase_q[gnt_id] : '0;
   assign bus.dout0    = dout_q[0];
   assign bus.dout1    = dout_q[1];
   assign bus.valid0   = valid_q[0];
   assign bus.valid1   = valid_q[1];
   assign bus.overrun  = overrun_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            phase_q[c] <= '0;
            dout_q[c]  <= '0;
         end
         pending_q <= '0;
         valid_q   <= '0;
         rr_ptr_q  <= '0;
         infl_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         valid_q <= '0;
         // The capture lands even under ph_clr; only its valid pulse is withheld.
         if (infl_q.valid) begin
            dout_q[infl_q.tag]  <= bus.rom_dout;
            valid_q[infl_q.tag] <= ~bus.ph_clr;
         end

         if (bus.ph_clr) begin
            for (int c = 0; c < NUM_CH; c++) begin
               phase_q[c] <= '0;
            end
            pending_q <= '0;
            rr_ptr_q  <= '0;
            infl_q    <= '0;
            overrun_q <= 1'b0;
         end else begin
            infl_q <= '{valid: gnt_valid, tag: gnt_id};
            if (gnt_valid) begin
               phase_q[gnt_id] <= phase_q[gnt_id] + incr_w[gnt_id];
               rr_ptr_q        <= ~gnt_id;
            end
            // A new tick re-arms a channel even as it is being served; it only
            // overruns when the earlier request is still waiting for the ROM.
            for (int c = 0; c < NUM_CH; c++) begin
               if (tick_acc) begin
                  pending_q[c] <= 1'b1;
                  if (pending_q[c] && !(gnt_valid && gnt_id == ch_id_t'(c))) begin
                     overrun_q <= 1'b1;
                  end
               end else if (gnt_valid && gnt_id == ch_id_t'(c)) begin
                  pending_q[c] <= 1'b0;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_sine_rom_sched.sv
// Scoreboard bench for sine_rom_sched with a behavioural ROM and channel model.
module tb_sine_rom_sched;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] exp0[$];
   logic [7:0] exp1[$];
   int         evlog[$];
   logic [7:0] mph [2];
   logic [7:0] minc[2];
   logic [7:0] rom_q;

   always #5 clk = ~clk;

   sine_rom_sched_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) ifc ();

   sine_rom_sched #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   function automatic logic [7:0] rom_data(logic [7:0] a);
      return {a[3:0], a[7:4]} ^ 8'h3C;
   endfunction

   always @(posedge clk) rom_q <= rom_data(ifc.rom_addr);
   assign ifc.rom_dout = rom_q;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Monitor: every valid pulse pops the owning channel's expected sample.
   always @(negedge clk) begin
      if (ifc.valid0) begin
         evlog.push_back(0);
         if (exp0.size() == 0) chk("unexp_valid0", 1, 0);
         else chk("dout0", ifc.dout0, exp0.pop_front());
      end
      if (ifc.valid1) begin
         evlog.push_back(1);
         if (exp1.size() == 0) chk("unexp_valid1", 1, 0);
         else chk("dout1", ifc.dout1, exp1.pop_front());
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_incr(logic [7:0] a, logic [7:0] b);
      ifc.incr0 = a;
      ifc.incr1 = b;
      minc[0]   = a;
      minc[1]   = b;
   endtask

   // Each accepted tick (spaced so no request is merged) yields one sample per channel.
   task automatic do_tick();
      logic acc;
      acc      = ifc.en;
      ifc.tick = 1'b1;
      cyc();
      ifc.tick = 1'b0;
      if (acc) begin
         exp0.push_back(rom_data(mph[0]));
         exp1.push_back(rom_data(mph[1]));
         mph[0] = mph[0] + minc[0];
         mph[1] = mph[1] + minc[1];
      end
   endtask

   task automatic clr_phases();
      ifc.ph_clr = 1'b1;
      cyc();
      ifc.ph_clr = 1'b0;
      mph[0] = '0;
      mph[1] = '0;
   endtask

   task automatic drained(string nm);
      repeat (5) cyc();
      chk({nm, "_q0"}, exp0.size(), 0);
      chk({nm, "_q1"}, exp1.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int start;
      int nv;
      rst_n = 1'b0;
      ifc.en = 1'b0; ifc.tick = 1'b0; ifc.ph_clr = 1'b0;
      set_incr(8'd0, 8'd0);
      mph[0] = '0; mph[1] = '0;
      repeat (2) cyc();
      chk("rst_dout0", ifc.dout0, 0);
      chk("rst_dout1", ifc.dout1, 0);
      chk("rst_valid", {ifc.valid1, ifc.valid0}, 0);
      chk("rst_overrun", ifc.overrun, 0);
      chk("rst_addr", ifc.rom_addr, 0);
      rst_n = 1'b1;
      cyc();

      // Single tick latency, incr0=1 incr1=4.
      ifc.en = 1'b1;
      set_incr(8'd1, 8'd4);
      do_tick();
      chk("t1_addr_ch0", ifc.rom_addr, 0);
      cyc();
      chk("t1_v0_early", ifc.valid0, 0);
      chk("t1_addr_ch1", ifc.rom_addr, 0);
      cyc();
      chk("t1_v0_c3", ifc.valid0, 1);
      chk("t1_v1_c3", ifc.valid1, 0);
      cyc();
      chk("t1_v1_c4", ifc.valid1, 1);
      chk("t1_v0_c4", ifc.valid0, 0);
      repeat (2) cyc();
      do_tick();
      chk("t1_ph0", ifc.rom_addr, 1);
      cyc();
      chk("t1_ph1", ifc.rom_addr, 4);
      drained("t1");

      // 70 samples with incr0=4 so ch0 wraps; gaps of 2..4 cycles.
      set_incr(8'd4, 8'($urandom));
      for (int i = 0; i < 70; i++) begin
         do_tick();
         repeat ($urandom_range(1, 3)) cyc();
      end
      drained("wrap");
      chk("wrap_overrun", ifc.overrun, 0);

      // Random increments and en toggling, en may drop mid-drain.
      for (int i = 0; i < 40; i++) begin
         ifc.en = ($urandom_range(0, 3) != 0);
         do_tick();
         ifc.en = $urandom_range(0, 1);
         repeat ($urandom_range(2, 3)) cyc();
         set_incr(8'($urandom), 8'($urandom));
      end
      drained("rand");
      chk("rand_overrun", ifc.overrun, 0);

      // Tick with en low: no ROM traffic, no samples.
      ifc.en = 1'b0;
      nv = evlog.size();
      do_tick();
      for (int i = 0; i < 4; i++) begin
         chk("en0_addr", ifc.rom_addr, 0);
         cyc();
      end
      chk("en0_novalid", evlog.size(), nv);
      ifc.en = 1'b1;
      do_tick();
      drained("en0");

      // Back-to-back ticks: overrun on the second, ch0 served twice, ch1 once.
      clr_phases();
      set_incr(8'd3, 8'd5);
      start = evlog.size();
      ifc.tick = 1'b1;
      cyc();
      chk("b2b_ovr_first", ifc.overrun, 0);
      cyc();
      ifc.tick = 1'b0;
      chk("b2b_ovr_second", ifc.overrun, 1);
      exp0.push_back(rom_data(8'd0));
      exp0.push_back(rom_data(8'd3));
      exp1.push_back(rom_data(8'd0));
      mph[0] = 8'd6; mph[1] = 8'd5;
      repeat (6) cyc();
      chk("b2b_nsamples", evlog.size() - start, 3);
      if (evlog.size() - start == 3) begin
         chk("b2b_order0", evlog[start], 0);
         chk("b2b_order1", evlog[start+1], 1);
         chk("b2b_order2", evlog[start+2], 0);
      end
      chk("b2b_ovr_sticky", ifc.overrun, 1);
      drained("b2b");
      clr_phases();
      chk("b2b_ovr_clr", ifc.overrun, 0);

      // ph_clr on the ch1 capture edge: data lands, valid suppressed.
      set_incr(8'd9, 8'd17);
      do_tick();
      drained("pc_pre");
      ifc.tick = 1'b1;
      cyc();
      ifc.tick = 1'b0;
      exp0.push_back(rom_data(mph[0]));
      cyc();
      cyc();
      ifc.ph_clr = 1'b1;
      cyc();
      ifc.ph_clr = 1'b0;
      mph[0] = '0; mph[1] = '0;
      chk("pc_valid1", ifc.valid1, 0);
      chk("pc_dout1", ifc.dout1, rom_data(8'd17));
      chk("pc_overrun", ifc.overrun, 0);
      do_tick();
      chk("pc_addr_ch0", ifc.rom_addr, 0);
      cyc();
      chk("pc_addr_ch1", ifc.rom_addr, 0);
      drained("pc");

      // Async reset between issue and capture.
      do_tick();
      cyc();
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_dout0", ifc.dout0, 0);
      chk("ar_dout1", ifc.dout1, 0);
      chk("ar_valid", {ifc.valid1, ifc.valid0}, 0);
      chk("ar_addr", ifc.rom_addr, 0);
      exp0.delete();
      exp1.delete();
      mph[0] = '0; mph[1] = '0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      nv = evlog.size();
      repeat (5) cyc();
      chk("ar_novalid", evlog.size(), nv);
      do_tick();
      drained("ar");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
